pat_stream_tx: RTL

- Serial bit-stream transmitter: the source side of the serial detector interface (single data bit plus valid qualifier, one bit per clock).
- Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first with a per-bit valid strobe.
- Repeats the word a programmable number of times, with a fixed number of idle (valid-low) cycles after each repetition.
- Used to drive pattern detectors in system test and in the team's benches.

---
 rtl/pat_pkg.sv | 24 ++
 rtl/pat_piso.sv | 38 +++
 rtl/pat_stream_tx.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pat_pkg.sv
// Shared definitions for the serial pattern transmitter.
package pat_pkg;

  // One-hot controller states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_SHIFT = 3'b010,
    S_GAP   = 3'b100
  } state_t;

  // Line levels used when building or idling the serial stream.
  localparam logic B = 1'b1;
  localparam logic C = 1'b0;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_REP_W  = 4;
  localparam int DEF_GAP    = 2;

  // Width of a down-counter that must hold values 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pat_piso.sv
// Parallel-in serial-out register, MSB first. Exposes the MSB the register
// will hold after this edge so the caller can register it alongside state.
module pat_piso #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic              msb_next
);

  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] sreg_n;

  // Load has priority over shift; zeros fill in from the LSB side.
  always_comb begin
    sreg_n = sreg;
    if (load) begin
      sreg_n = din;
    end else if (shift) begin
      sreg_n = {sreg[WORD_W-2:0], 1'b0};
    end
  end

  // Shift register storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else begin
      sreg <= sreg_n;
    end
  end

  assign msb_next = sreg_n[WORD_W-1];

endmodule

// File: rtl/pat_stream_tx.sv
// Serial pattern transmitter: accepts a word over valid/ready and sends it
// MSB-first, repeated rep_i times, each repetition followed by GAP idle cycles.
//
// state   | meaning
// S_IDLE  | waiting for a word; word_ready_o high
// S_SHIFT | one valid bit per cycle from the shift register
// S_GAP   | valid-low spacing after a repetition
module pat_stream_tx
  import pat_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int REP_W  = DEF_REP_W,
  parameter int GAP    = DEF_GAP
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [REP_W-1:0]  rep_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  output logic              dout_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int BIT_W = cnt_w(WORD_W);
  localparam int GAP_W = cnt_w(GAP);

  state_t            state, state_n;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [REP_W-1:0]  rep_cnt, rep_cnt_n;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
  logic [WORD_W-1:0] hold, hold_n;
  logic [WORD_W-1:0] load_val;
  logic              load, shift, done_n;
  logic              piso_msb;

  pat_piso #(.WORD_W(WORD_W)) u_piso (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (load),
    .shift    (shift),
    .din      (load_val),
    .msb_next (piso_msb)
  );

  // Next-state, counter and shift-register control.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    rep_cnt_n = rep_cnt;
    gap_cnt_n = gap_cnt;
    hold_n    = hold;
    load_val  = hold;
    load      = 1'b0;
    shift     = 1'b0;
    done_n    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (word_valid_i && word_ready_o) begin
          load      = 1'b1;
          load_val  = word_i;
          hold_n    = word_i;
          rep_cnt_n = (rep_i == '0) ? REP_W'(1) : rep_i;
          bit_cnt_n = BIT_W'(WORD_W - 1);
          state_n   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_cnt != '0) begin
          shift     = 1'b1;
          bit_cnt_n = bit_cnt - BIT_W'(1);
        end else begin
          // Last bit of a repetition: rearm the register from the held copy.
          load      = 1'b1;
          bit_cnt_n = BIT_W'(WORD_W - 1);
          rep_cnt_n = rep_cnt - REP_W'(1);
          done_n    = (rep_cnt == REP_W'(1));
          if (GAP > 0) begin
            gap_cnt_n = GAP_W'((GAP > 0) ? GAP - 1 : 0);
            state_n   = S_GAP;
          end else if (rep_cnt != REP_W'(1)) begin
            state_n = S_SHIFT;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          state_n = (rep_cnt != '0) ? S_SHIFT : S_IDLE;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      rep_cnt      <= '0;
      gap_cnt      <= '0;
      hold         <= '0;
      dout_o       <= 1'b0;
      valid_o      <= 1'b0;
      word_ready_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      rep_cnt      <= rep_cnt_n;
      gap_cnt      <= gap_cnt_n;
      hold         <= hold_n;
      dout_o       <= (state_n == S_SHIFT) ? piso_msb : C;
      valid_o      <= (state_n == S_SHIFT) ? B : C;
      word_ready_o <= (state_n == S_IDLE) ? B : C;
      busy_o       <= (state_n != S_IDLE) ? B : C;
      done_o       <= done_n;
    end
  end

endmodule
